// File: rtl/bus1_pkg.sv
// bus1_pkg: shared bus-1 command codes and bus widths used by the arbiter and its requesters.
package bus1_pkg;

    localparam int ADDR1_BUS_SIZE = 15;
    localparam int DATA_BUS_SIZE  = 16;
    localparam int CTR1_BUS_SIZE  = 3;

    typedef logic [CTR1_BUS_SIZE-1:0] c1_t;

    localparam c1_t C1_NOP             = 3'd0;
    localparam c1_t C1_READ8           = 3'd1;
    localparam c1_t C1_READ16          = 3'd2;
    localparam c1_t C1_READ32          = 3'd3;
    localparam c1_t C1_INVALIDATE_LINE = 3'd4;
    localparam c1_t C1_WRITE8          = 3'd5;
    localparam c1_t C1_WRITE16         = 3'd6;
    localparam c1_t C1_WRITE32         = 3'd7;
    // Responses only travel cache->requester, so RESPONSE can share WRITE32's code.
    localparam c1_t C1_RESPONSE        = 3'd7;

endpackage

// File: rtl/bus1_arbiter.sv
// bus1_arbiter: two-requester round-robin arbiter for bus 1 with per-transaction timeout.
module bus1_arbiter
    import bus1_pkg::*;
#(
    parameter int ADDR1_BUS_SIZE = bus1_pkg::ADDR1_BUS_SIZE,
    parameter int DATA_BUS_SIZE  = bus1_pkg::DATA_BUS_SIZE,
    parameter int CTR1_BUS_SIZE  = bus1_pkg::CTR1_BUS_SIZE,
    parameter int WAIT_LIMIT     = 255
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [CTR1_BUS_SIZE-1:0]  R0_C1,
    input  logic [CTR1_BUS_SIZE-1:0]  R1_C1,
    input  logic [ADDR1_BUS_SIZE-1:0] R0_A1,
    input  logic [ADDR1_BUS_SIZE-1:0] R1_A1,
    input  logic [DATA_BUS_SIZE-1:0]  R0_D1,
    input  logic [DATA_BUS_SIZE-1:0]  R1_D1,
    output logic [CTR1_BUS_SIZE-1:0]  R0_C1_RSP,
    output logic [CTR1_BUS_SIZE-1:0]  R1_C1_RSP,
    output logic [DATA_BUS_SIZE-1:0]  R0_D1_RSP,
    output logic [DATA_BUS_SIZE-1:0]  R1_D1_RSP,
    output logic [1:0]                RX_ERR,
    output logic [1:0]                GNT,
    output logic [CTR1_BUS_SIZE-1:0]  C_C1,
    output logic [ADDR1_BUS_SIZE-1:0] C_A1,
    output logic [DATA_BUS_SIZE-1:0]  C_D1,
    input  logic [CTR1_BUS_SIZE-1:0]  C_C1_RSP,
    input  logic [DATA_BUS_SIZE-1:0]  C_D1_RSP
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_BEAT2  = 2'd2;

    localparam int CNT_W = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;

    localparam logic [CTR1_BUS_SIZE-1:0] NOP    = CTR1_BUS_SIZE'(C1_NOP);
    localparam logic [CTR1_BUS_SIZE-1:0] RD32   = CTR1_BUS_SIZE'(C1_READ32);
    localparam logic [CTR1_BUS_SIZE-1:0] RSP    = CTR1_BUS_SIZE'(C1_RESPONSE);
    localparam logic [CNT_W-1:0]         CNT_TO = CNT_W'(WAIT_LIMIT - 1);

    logic [1:0]       state;
    logic             rr;
    logic             is_read32;
    logic [CNT_W-1:0] cnt;

    logic req0, req1, pick1, any_req, rsp_seen, timed_out;

    assign req0      = R0_C1 != NOP;
    assign req1      = R1_C1 != NOP;
    assign any_req   = req0 | req1;
    assign pick1     = req1 & (~req0 | rr);
    assign rsp_seen  = C_C1_RSP == RSP;
    // Counter holds k during the k-th granted cycle, so the limit is hit on the edge ending cycle WAIT_LIMIT-1.
    assign timed_out = cnt == CNT_TO;

    assign C_C1 = GNT[0] ? R0_C1 : GNT[1] ? R1_C1 : NOP;
    assign C_A1 = GNT[0] ? R0_A1 : GNT[1] ? R1_A1 : '0;
    assign C_D1 = GNT[0] ? R0_D1 : GNT[1] ? R1_D1 : '0;

    assign R0_C1_RSP = GNT[0] ? C_C1_RSP : NOP;
    assign R1_C1_RSP = GNT[1] ? C_C1_RSP : NOP;
    assign R0_D1_RSP = GNT[0] ? C_D1_RSP : '0;
    assign R1_D1_RSP = GNT[1] ? C_D1_RSP : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            GNT       <= '0;
            rr        <= 1'b0;
            is_read32 <= 1'b0;
            cnt       <= '0;
            RX_ERR    <= '0;
        end else begin
            RX_ERR <= '0;
            case (state)
                S_IDLE: if (any_req) begin
                    GNT       <= pick1 ? 2'b10 : 2'b01;
                    rr        <= ~pick1;
                    is_read32 <= (pick1 ? R1_C1 : R0_C1) == RD32;
                    cnt       <= '0;
                    state     <= S_ACTIVE;
                end
                S_ACTIVE: if (rsp_seen) begin
                    state <= is_read32 ? S_BEAT2 : S_IDLE;
                    GNT   <= is_read32 ? GNT : 2'b00;
                end else if (timed_out) begin
                    RX_ERR <= GNT;
                    GNT    <= '0;
                    state  <= S_IDLE;
                end else begin
                    cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                end
                default: begin
                    GNT   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus1_arbiter.sv
// tb_bus1_arbiter: directed scenario bench for bus1_arbiter with hand-computed expectations.
module tb_bus1_arbiter;
    import bus1_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [2:0]  R0_C1 = C1_NOP, R1_C1 = C1_NOP;
    logic [14:0] R0_A1 = '0, R1_A1 = '0;
    logic [15:0] R0_D1 = '0, R1_D1 = '0;
    logic [2:0]  R0_C1_RSP, R1_C1_RSP;
    logic [15:0] R0_D1_RSP, R1_D1_RSP;
    logic [1:0]  RX_ERR, GNT;
    logic [2:0]  C_C1;
    logic [14:0] C_A1;
    logic [15:0] C_D1;
    logic [2:0]  C_C1_RSP = C1_NOP;
    logic [15:0] C_D1_RSP = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    bus1_arbiter #(.WAIT_LIMIT(10)) dut (
        .CLK(CLK), .RESET(RESET),
        .R0_C1(R0_C1), .R1_C1(R1_C1), .R0_A1(R0_A1), .R1_A1(R1_A1),
        .R0_D1(R0_D1), .R1_D1(R1_D1),
        .R0_C1_RSP(R0_C1_RSP), .R1_C1_RSP(R1_C1_RSP),
        .R0_D1_RSP(R0_D1_RSP), .R1_D1_RSP(R1_D1_RSP),
        .RX_ERR(RX_ERR), .GNT(GNT),
        .C_C1(C_C1), .C_A1(C_A1), .C_D1(C_D1),
        .C_C1_RSP(C_C1_RSP), .C_D1_RSP(C_D1_RSP)
    );

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (GNT !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", GNT); end
        n_checks++; if (C_C1 !== C1_NOP || C_A1 !== 15'd0 || C_D1 !== 16'd0) begin n_fail++; $display("FAIL reset_cache_bus: got %h/%h/%h expected 0/0/0", C_C1, C_A1, C_D1); end
        n_checks++; if (RX_ERR !== 2'b00) begin n_fail++; $display("FAIL reset_rx_err: got %b expected 00", RX_ERR); end
        @(negedge CLK);
        RESET = 1'b0;
        R0_A1 = 15'h0123;
        @(negedge CLK); #1;
        n_checks++; if (R0_C1_RSP !== C1_NOP || R1_C1_RSP !== C1_NOP || R0_D1_RSP !== 16'd0) begin n_fail++; $display("FAIL reset_rsp: got %h/%h/%h expected 0/0/0", R0_C1_RSP, R1_C1_RSP, R0_D1_RSP); end
        n_checks++; if (GNT !== 2'b00 || C_A1 !== 15'd0) begin n_fail++; $display("FAIL post_reset_idle: got gnt %b addr %h expected 00/0", GNT, C_A1); end
    endtask

    task automatic test_single_read16();
        R0_C1 = C1_READ16; R0_A1 = 15'h1234;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (k == 1) R0_C1 = C1_NOP;
            if (k == 7) begin C_C1_RSP = C1_RESPONSE; C_D1_RSP = 16'hBEEF; end
            #1;
            n_checks++; if (GNT !== 2'b01) begin n_fail++; $display("FAIL rd16_gnt cycle %0d: got %b expected 01", k, GNT); end
            n_checks++; if (R1_C1_RSP !== C1_NOP) begin n_fail++; $display("FAIL rd16_r1_rsp cycle %0d: got %h expected 0", k, R1_C1_RSP); end
            if (k == 0) begin
                n_checks++; if (C_C1 !== C1_READ16 || C_A1 !== 15'h1234) begin n_fail++; $display("FAIL rd16_cmd: got %h/%h expected 2/1234", C_C1, C_A1); end
            end
            if (k == 7) begin
                n_checks++; if (R0_C1_RSP !== C1_RESPONSE || R0_D1_RSP !== 16'hBEEF) begin n_fail++; $display("FAIL rd16_data: got %h/%h expected 7/beef", R0_C1_RSP, R0_D1_RSP); end
            end
        end
        @(negedge CLK);
        C_C1_RSP = C1_NOP; C_D1_RSP = '0;
        #1;
        n_checks++; if (GNT !== 2'b00) begin n_fail++; $display("FAIL rd16_release: got %b expected 00", GNT); end
    endtask

    task automatic test_both_read8();
        do_reset();
        R0_C1 = C1_READ8; R1_C1 = C1_READ8; R0_A1 = 15'h0AA0; R1_A1 = 15'h0BB0;
        @(negedge CLK); #1;
        n_checks++; if (GNT !== 2'b01 || C_A1 !== 15'h0AA0) begin n_fail++; $display("FAIL both_first: got %b/%h expected 01/0aa0", GNT, C_A1); end
        C_C1_RSP = C1_RESPONSE; R0_C1 = C1_NOP;
        @(negedge CLK);
        C_C1_RSP = C1_NOP;
        #1;
        n_checks++; if (GNT !== 2'b00 || C_C1 !== C1_NOP) begin n_fail++; $display("FAIL both_turnaround: got %b/%h expected 00/0", GNT, C_C1); end
        @(negedge CLK); #1;
        n_checks++; if (GNT !== 2'b10 || C_A1 !== 15'h0BB0) begin n_fail++; $display("FAIL both_second: got %b/%h expected 10/0bb0", GNT, C_A1); end
        C_C1_RSP = C1_RESPONSE; R1_C1 = C1_NOP;
        @(negedge CLK);
        C_C1_RSP = C1_NOP;
        R0_C1 = C1_READ8; R1_C1 = C1_READ8;
        @(negedge CLK); #1;
        n_checks++; if (GNT !== 2'b01) begin n_fail++; $display("FAIL both_rr_back: got %b expected 01", GNT); end
        C_C1_RSP = C1_RESPONSE; R0_C1 = C1_NOP; R1_C1 = C1_NOP;
        @(negedge CLK);
        C_C1_RSP = C1_NOP;
        @(negedge CLK);
    endtask

    task automatic test_read32();
        R1_C1 = C1_READ32; R1_A1 = 15'h3000;
        @(negedge CLK); #1;
        n_checks++; if (GNT !== 2'b10 || C_C1 !== C1_READ32) begin n_fail++; $display("FAIL rd32_gnt: got %b/%h expected 10/3", GNT, C_C1); end
        @(negedge CLK);
        @(negedge CLK);
        C_C1_RSP = C1_RESPONSE; C_D1_RSP = 16'h1234; R1_C1 = C1_NOP;
        #1;
        n_checks++; if (R1_D1_RSP !== 16'h1234 || R1_C1_RSP !== C1_RESPONSE) begin n_fail++; $display("FAIL rd32_beat1: got %h/%h expected 1234/7", R1_D1_RSP, R1_C1_RSP); end
        n_checks++; if (R0_C1_RSP !== C1_NOP || R0_D1_RSP !== 16'd0) begin n_fail++; $display("FAIL rd32_r0_quiet: got %h/%h expected 0/0", R0_C1_RSP, R0_D1_RSP); end
        @(negedge CLK);
        C_C1_RSP = C1_NOP; C_D1_RSP = 16'hABCD;
        #1;
        n_checks++; if (GNT !== 2'b10 || R1_D1_RSP !== 16'hABCD) begin n_fail++; $display("FAIL rd32_beat2: got %b/%h expected 10/abcd", GNT, R1_D1_RSP); end
        @(negedge CLK);
        C_D1_RSP = '0;
        #1;
        n_checks++; if (GNT !== 2'b00) begin n_fail++; $display("FAIL rd32_release: got %b expected 00", GNT); end
    endtask

    task automatic test_timeout();
        R0_C1 = C1_WRITE16; R0_A1 = 15'h0444; R0_D1 = 16'h5555;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK); #1;
            n_checks++; if (GNT !== 2'b01 || RX_ERR !== 2'b00) begin n_fail++; $display("FAIL to_wait cycle %0d: got %b/%b expected 01/00", k, GNT, RX_ERR); end
            if (k == 0) begin
                n_checks++; if (C_D1 !== 16'h5555) begin n_fail++; $display("FAIL to_wdata: got %h expected 5555", C_D1); end
            end
        end
        @(negedge CLK); #1;
        n_checks++; if (RX_ERR !== 2'b01 || GNT !== 2'b00) begin n_fail++; $display("FAIL to_err: got %b/%b expected 01/00", RX_ERR, GNT); end
        R0_C1 = C1_NOP; R1_C1 = C1_READ8;
        @(negedge CLK); #1;
        n_checks++; if (RX_ERR !== 2'b00 || GNT !== 2'b10) begin n_fail++; $display("FAIL to_next: got %b/%b expected 00/10", RX_ERR, GNT); end
        C_C1_RSP = C1_RESPONSE; R1_C1 = C1_NOP;
        @(negedge CLK);
        C_C1_RSP = C1_NOP;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        R0_C1 = C1_READ8;
        @(negedge CLK); #1;
        n_checks++; if (GNT !== 2'b01) begin n_fail++; $display("FAIL rst_mid_gnt: got %b expected 01", GNT); end
        RESET = 1'b1;
        R1_C1 = C1_READ8;
        #1;
        n_checks++; if (GNT !== 2'b00 || C_C1 !== C1_NOP || R0_C1_RSP !== C1_NOP) begin n_fail++; $display("FAIL rst_mid_async: got %b/%h/%h expected 00/0/0", GNT, C_C1, R0_C1_RSP); end
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK); #1;
        n_checks++; if (GNT !== 2'b01) begin n_fail++; $display("FAIL rst_mid_rr: got %b expected 01", GNT); end
        C_C1_RSP = C1_RESPONSE; R0_C1 = C1_NOP;
        @(negedge CLK);
        C_C1_RSP = C1_NOP;
        @(negedge CLK); #1;
        n_checks++; if (GNT !== 2'b10) begin n_fail++; $display("FAIL rst_mid_r1: got %b expected 10", GNT); end
        C_C1_RSP = C1_RESPONSE; R1_C1 = C1_NOP;
        @(negedge CLK);
        C_C1_RSP = C1_NOP;
        @(negedge CLK);
    endtask

    task automatic test_invalidate();
        R0_C1 = C1_INVALIDATE_LINE; R0_A1 = 15'h0777;
        @(negedge CLK); #1;
        n_checks++; if (GNT !== 2'b01 || C_C1 !== C1_INVALIDATE_LINE) begin n_fail++; $display("FAIL inv_gnt: got %b/%h expected 01/4", GNT, C_C1); end
        R1_C1 = C1_READ8;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #1;
            n_checks++; if (GNT !== 2'b01 || R1_C1_RSP !== C1_NOP) begin n_fail++; $display("FAIL inv_r1_waits cycle %0d: got %b/%h expected 01/0", k, GNT, R1_C1_RSP); end
        end
        C_C1_RSP = C1_RESPONSE; R0_C1 = C1_NOP;
        @(negedge CLK);
        C_C1_RSP = C1_NOP;
        #1;
        n_checks++; if (GNT !== 2'b00) begin n_fail++; $display("FAIL inv_single_beat: got %b expected 00", GNT); end
        @(negedge CLK); #1;
        n_checks++; if (GNT !== 2'b10 || C_C1 !== C1_READ8) begin n_fail++; $display("FAIL inv_r1_granted: got %b/%h expected 10/1", GNT, C_C1); end
        C_C1_RSP = C1_RESPONSE; R1_C1 = C1_NOP;
        @(negedge CLK);
        C_C1_RSP = C1_NOP;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_single_read16();
        test_both_read8();
        test_read32();
        test_timeout();
        test_reset_mid();
        test_invalidate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
